// File: rtl/alu_frame_pkg.sv
// Shared encodings for the framed ALU command sequencer: FSM states, response
// status codes and the default frame delimiter.
package alu_frame_pkg;

  typedef enum logic [3:0] {
    IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, TX_SOF, TX_STAT, TX_RES, TX_CHK
  } state_t;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_BAD_CHK = 8'h01;
  localparam logic [7:0] STAT_TIMEOUT = 8'h02;

  localparam logic [7:0] SOF_DEFAULT  = 8'hA5;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte watchdog: counts enabled idle cycles, pulses expired on the cycle
// that would take the count to TIMEOUT_CYCLES. Clear has priority.
module uart_byte_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expired = en & ~clr & (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Saturates at the terminal count so expired cannot re-fire before a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 cnt <= '0;
    else if (clr)                                 cnt <= '0;
    else if (en && cnt != CW'(TIMEOUT_CYCLES))    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/alu_frame_sequencer.sv
// Framed UART command sequencer driving a combinational ALU, with inter-byte
// timeout and error counting. Define ALU_FRAME_CHECKSUM_EN for checksum bytes.
module alu_frame_sequencer
  import alu_frame_pkg::*;
#(
  parameter int         REG_SIZE       = 8,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rx_empty,
  input  logic [7:0]                 r_data,
  output logic                       rd_uart,
  input  logic                       tx_full,
  output logic                       wr_uart,
  output logic [7:0]                 w_data,
  output logic signed [REG_SIZE-1:0] a,
  output logic signed [REG_SIZE-1:0] b,
  output logic [REG_SIZE-1:0]        op,
  input  logic signed [REG_SIZE-1:0] w,
  output logic                       busy,
  output logic [7:0]                 err_count
);

  state_t     state, state_nxt;
  logic [7:0] result, status;
  logic       in_get, in_tx, expired;

  assign in_get = (state == GET_OP) || (state == GET_A) || (state == GET_B) ||
                  (state == GET_CHK);
  assign in_tx  = (state == TX_SOF) || (state == TX_STAT) || (state == TX_RES) ||
                  (state == TX_CHK);

  uart_byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (rd_uart | (state == IDLE)),
    .en      (in_get),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_uart && r_data == SOF_BYTE) state_nxt = GET_OP;
      GET_OP:  if (rd_uart) state_nxt = GET_A;   else if (expired) state_nxt = TX_SOF;
      GET_A:   if (rd_uart) state_nxt = GET_B;   else if (expired) state_nxt = TX_SOF;
`ifdef ALU_FRAME_CHECKSUM_EN
      GET_B:   if (rd_uart) state_nxt = GET_CHK; else if (expired) state_nxt = TX_SOF;
      GET_CHK: if (rd_uart) state_nxt = EXEC;    else if (expired) state_nxt = TX_SOF;
      TX_RES:  if (wr_uart) state_nxt = TX_CHK;
      TX_CHK:  if (wr_uart) state_nxt = IDLE;
`else
      GET_B:   if (rd_uart) state_nxt = EXEC;    else if (expired) state_nxt = TX_SOF;
      TX_RES:  if (wr_uart) state_nxt = IDLE;
`endif
      EXEC:    state_nxt = TX_SOF;
      TX_SOF:  if (wr_uart) state_nxt = TX_STAT;
      TX_STAT: if (wr_uart) state_nxt = TX_RES;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_uart = (state == IDLE || in_get) && !rx_empty;
    wr_uart = in_tx && !tx_full;
    busy    = (state != IDLE);
    case (state)
      TX_STAT: w_data = status;
      TX_RES:  w_data = result;
      TX_CHK:  w_data = status ^ result;
      default: w_data = SOF_BYTE;
    endcase
  end

  // Operand/status datapath; a pop in a GET state outranks the timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op        <= '0;
      a         <= '0;
      b         <= '0;
      result    <= '0;
      status    <= STAT_OK;
      err_count <= '0;
    end else begin
      if (rd_uart) begin
        case (state)
          IDLE:    if (r_data == SOF_BYTE) status <= STAT_OK;
          GET_OP:  op <= r_data;
          GET_A:   a  <= r_data;
          GET_B:   b  <= r_data;
          GET_CHK: status <= (r_data == (op ^ a ^ b)) ? STAT_OK : STAT_BAD_CHK;
          default: ;
        endcase
      end else if (in_get && expired) begin
        status <= STAT_TIMEOUT;
        result <= '0;
      end
      if (state == EXEC)
        result <= (status == STAT_OK) ? w : '0;
      if (state == TX_STAT && wr_uart && status != STAT_OK && err_count != 8'hFF)
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Scoreboard bench: stimulus queues RX bytes and expected TX bytes; a monitor
// models the FIFOs and checks every push against the expected queue.
module tb_alu_frame_sequencer;

  logic              clk = 1'b0, reset_n = 1'b0;
  logic              rx_empty = 1'b1, tx_full = 1'b0;
  logic [7:0]        r_data = 8'h00;
  logic              rd_uart, wr_uart, busy;
  logic [7:0]        w_data, err_count, op;
  logic signed [7:0] a, b, w;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  int errors = 0, checks = 0;
  int exp_err = 0;

`ifdef ALU_FRAME_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  assign w = a + b;

  alu_frame_sequencer #(.REG_SIZE(8), .TIMEOUT_CYCLES(16), .SOF_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .a(a), .b(b), .op(op), .w(w), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIFO model + scoreboard monitor: sample at negedge, apply pops after the edge.
  always begin
    logic pend;
    logic [7:0] e;
    @(negedge clk);
    pend = 1'b0;
    if (reset_n) begin
      if (rd_uart && wr_uart) begin
        checks++; errors++;
        $display("FAIL rd_wr_same_cycle: got both strobes expected one");
      end
      if (rd_uart) pend = 1'b1;
      if (wr_uart) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_push: got %h expected none", w_data);
        end else begin
          e = expq.pop_front();
          check8("tx_byte", w_data, e);
        end
      end
    end
    @(posedge clk); #1;
    if (pend && rxq.size() > 0) void'(rxq.pop_front());
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  end

  task automatic frame(input logic [7:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] c);
    rxq.push_back(8'hA5); rxq.push_back(o); rxq.push_back(x); rxq.push_back(y);
    if (CHK) rxq.push_back(c);
  endtask

  task automatic expect_resp(input logic [7:0] st, input logic [7:0] res);
    expq.push_back(8'hA5); expq.push_back(st); expq.push_back(res);
    if (CHK) expq.push_back(st ^ res);
  endtask

  task automatic wait_idle(input string name);
    int n;
    repeat (3) @(posedge clk);
    n = 0;
    while ((rxq.size() != 0 || expq.size() != 0 || busy) && n < 300) begin
      @(posedge clk); n++;
    end
    @(negedge clk);
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain: got rx=%0d tx=%0d busy=%0b expected all drained",
               name, rxq.size(), expq.size(), busy);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check8("rst_busy", {7'd0, busy}, 8'd0);
    check8("rst_err", err_count, 8'd0);
    check8("rst_op", op, 8'd0);
    check8("rst_a", a, 8'd0);
    check8("rst_b", b, 8'd0);
    check8("rst_strobes", {6'd0, rd_uart, wr_uart}, 8'd0);
    reset_n = 1'b1;

    // basic add frame
    @(posedge clk); #2;
    frame(8'h20, 8'h05, 8'h03, 8'h26); expect_resp(8'h00, 8'h08);
    wait_idle("basic");
    check8("basic_busy", {7'd0, busy}, 8'd0);
    check8("basic_err", err_count, 8'(exp_err));
    check8("basic_op", op, 8'h20);
    check8("basic_b", b, 8'h03);

    // leading garbage is dropped in IDLE
    @(posedge clk); #2;
    rxq.push_back(8'h11); rxq.push_back(8'h22);
    frame(8'h20, 8'h05, 8'h03, 8'h26); expect_resp(8'h00, 8'h08);
    wait_idle("garbage");
    check8("garbage_err", err_count, 8'(exp_err));

`ifdef ALU_FRAME_CHECKSUM_EN
    @(posedge clk); #2;
    frame(8'h20, 8'h05, 8'h03, 8'h27); expect_resp(8'h01, 8'h00);
    exp_err++;
    wait_idle("badchk");
    check8("badchk_err", err_count, 8'(exp_err));
`endif

    // timeout after A5 20
    @(posedge clk); #2;
    rxq.push_back(8'hA5); rxq.push_back(8'h20);
    expect_resp(8'h02, 8'h00);
    exp_err++;
    wait_idle("timeout");
    check8("timeout_err", err_count, 8'(exp_err));
    check8("timeout_op_kept", op, 8'h20);
    check8("timeout_a_kept", a, 8'h05);

    @(posedge clk); #2;
    frame(8'h10, 8'h07, 8'h09, 8'h1E); expect_resp(8'h00, 8'h10);
    wait_idle("post_timeout");
    check8("post_timeout_err", err_count, 8'(exp_err));

    // TX stall during TX_STAT; a queued frame must not be popped meanwhile
    @(posedge clk); #2;
    frame(8'h01, 8'h7F, 8'h01, 8'h7F); expect_resp(8'h00, 8'h80);
    n = 0;
    do begin @(negedge clk); n++; end while (!(wr_uart && w_data == 8'hA5) && n < 100);
    check8("stall_sof_seen", {7'd0, n < 100}, 8'd1);
    @(posedge clk); #1;
    tx_full = 1'b1;
    frame(8'h02, 8'h04, 8'h05, 8'h03); expect_resp(8'h00, 8'h09);
    repeat (10) begin
      @(negedge clk);
      check8("stall_no_push", {7'd0, wr_uart}, 8'd0);
      check8("stall_no_pop", {7'd0, rd_uart}, 8'd0);
    end
    @(posedge clk); #1;
    tx_full = 1'b0;
    wait_idle("stall");
    check8("stall_err", err_count, 8'(exp_err));

    // reset in the middle of GET_A
    @(posedge clk); #2;
    rxq.push_back(8'hA5); rxq.push_back(8'h20);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check8("mid_busy", {7'd0, busy}, 8'd1);
    check8("mid_op", op, 8'h20);
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check8("mrst_busy", {7'd0, busy}, 8'd0);
    check8("mrst_op", op, 8'd0);
    check8("mrst_a", a, 8'd0);
    check8("mrst_b", b, 8'd0);
    check8("mrst_err", err_count, 8'd0);
    reset_n = 1'b1;
    exp_err = 0;
    @(posedge clk); #2;
    frame(8'h20, 8'h05, 8'h03, 8'h26); expect_resp(8'h00, 8'h08);
    wait_idle("after_reset");
    check8("after_reset_err", err_count, 8'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_frame_sequencer.md
# alu_frame_sequencer

Framed command sequencer between the UART FIFOs and the combinational ALU. Receives a start-delimited command frame (opcode, operand A, operand B, optional checksum), drives the ALU operands, captures the result, and returns a framed response with a status byte. It adds an inter-byte receive timeout and error accounting, so a lost or corrupt byte cannot permanently misalign the operand stream.

## Interface
- `REG_SIZE`, default 8: ALU operand/result width; fixed at 8 (one UART byte per field).
- `TIMEOUT_CYCLES`, default 50000: idle clocks allowed between bytes of one frame.
- `SOF_BYTE`, default 8'hA5: start-of-frame delimiter, used both in and out.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_empty` in 1: RX FIFO empty flag.
- `r_data` in 8: RX FIFO head byte, valid while `rx_empty`=0.
- `rd_uart` out 1: RX FIFO pop strobe.
- `tx_full` in 1: TX FIFO full flag.
- `wr_uart` out 1: TX FIFO push strobe.
- `w_data` out 8: byte pushed when `wr_uart`=1.
- `a` out REG_SIZE signed: ALU operand A, registered.
- `b` out REG_SIZE signed: ALU operand B, registered.
- `op` out REG_SIZE: ALU opcode, registered.
- `w` in REG_SIZE signed: ALU result (combinational from a/b/op).
- `busy` out 1: high in every state except IDLE.
- `err_count` out 8: saturating count of error responses sent.

## Operation
- States: IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, TX_SOF, TX_STAT, TX_RES, TX_CHK.
- `rd_uart` = (IDLE or GET_*) & ~`rx_empty`, combinational. The byte on `r_data` is consumed on that same edge.
- IDLE: a popped byte ≠ `SOF_BYTE` is discarded, and the state stays IDLE. `SOF_BYTE` moves to GET_OP.
- GET_OP → GET_A → GET_B: each pop loads `op`, `a`, `b` in turn. Inside a frame, `SOF_BYTE` is treated as ordinary data; there is no resync.
- After GET_B the state goes to GET_CHK, or to EXEC when the checksum is compiled out.
- GET_CHK: pop compares the byte to `op`^`a`^`b`. Match sets status 8'h00 (OK); mismatch sets status 8'h01 (BAD_CHK). Both go to EXEC.
- EXEC: one cycle. The result register captures `w` at the end of EXEC if status is OK; otherwise it captures 8'h00. Then go to TX_SOF.
- TX_* states: `wr_uart` = ~`tx_full`, combinational. `w_data` is `SOF_BYTE`, then status, then result, then status^result. The state advances only on an accepted push. TX_RES goes to TX_CHK or IDLE; TX_CHK goes to IDLE.
- Timeout: a counter clears on every pop and in IDLE, and increments while in GET_*. On reaching `TIMEOUT_CYCLES`, the partial frame is aborted: status is 8'h02 (TIMEOUT), the result is 8'h00, and the state goes to TX_SOF. `a`/`b`/`op` keep their last loaded values.
- If a pop and the timeout terminal count occur in the same cycle, the pop wins.
- `err_count` increments, saturating at 8'hFF, on the TX_STAT push when status ≠ 0.

## Timing
- Reset values: state IDLE, `a`=`b`=`op`=0, result=0, status=0, timeout counter=0, `err_count`=0, `busy`=0. `rd_uart`=`wr_uart`=0 because the RX FIFO is empty after reset. `w_data`=`SOF_BYTE` (don't care).
- Reset mid-frame or mid-response abandons the frame. The FIFOs are not touched.
- Throughput: at most one pop or one push per cycle, never both.
- Latency: the last command byte is popped at edge N. EXEC occupies cycle N to N+1. The response SOF push is asserted in the cycle after edge N+1 if `tx_full`=0.
- `a`/`b`/`op` are stable from the pop that loads them through EXEC, so `w` has ≥1 full cycle to settle.
- While `tx_full`=1, the response stalls indefinitely and no RX bytes are popped.

## Configuration
- `ALU_FRAME_CHECKSUM_EN` defined: the command frame has 5 bytes (with CHK), the response has 4 bytes (with CHK), and the GET_CHK and TX_CHK states exist.
- `ALU_FRAME_CHECKSUM_EN` undefined: the command frame has 4 bytes and the response has 3. GET_CHK and TX_CHK are removed, and BAD_CHK is never produced.

## Structure
- Package `alu_frame_pkg` holds:
  - the state encoding;
  - the status constants STAT_OK=8'h00, STAT_BAD_CHK=8'h01, STAT_TIMEOUT=8'h02;
  - the default `SOF_BYTE`.
- One sub-module, `uart_byte_timer`: a clear/enable counter with parameter `TIMEOUT_CYCLES`. Its counter width is $clog2(`TIMEOUT_CYCLES`+1), and it outputs a one-cycle `expired` pulse.

## Test plan
- Checksum on, bytes A5 20 05 03 26 queued, bench ALU computes w=a+b → pushes A5 00 08 08, then `busy`=0 and `err_count`=0.
- Garbage 11 22 before A5 20 05 03 26 → 11 and 22 are popped and dropped, the response is identical to the previous case, and there is no extra push.
- Checksum byte 27 instead of 26 → pushes A5 01 00 01, and `err_count`=1.
- `TIMEOUT_CYCLES`=16, send A5 20 then starve RX for 16 cycles → pushes A5 02 00 02. The next valid frame then succeeds normally.
- Hold `tx_full`=1 for 10 cycles during TX_STAT → no push and no pop while stalled. After release, the remaining bytes are pushed in order with no duplication.
- Assert `reset_n`=0 mid GET_A, then release → IDLE, `a`=`b`=`op`=0, and the next full frame is processed correctly. Repeat with checksum compiled out: A5 20 05 03 → A5 00 08.
